// File: rtl/rand_candidate_shaper.sv
// rtl/rand_candidate_shaper.sv - collects a burst of random words and shapes it into an odd, full-width candidate
module rand_candidate_shaper #(
  parameter int REGISTER_SIZE = 32,
  parameter int BIT_SIZE      = 4096,
  parameter int MAX_RETRIES   = 3,
  parameter int TIMEOUT       = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start_in,
  input  logic [REGISTER_SIZE-1:0] rand_in,
  input  logic                     rand_valid_in,
  output logic                     trigger_out,
  output logic [REGISTER_SIZE-1:0] word_out,
  output logic                     word_valid_out,
  output logic                     word_last_out,
  output logic                     done_out,
  output logic                     fail_out,
  output logic                     busy_out
);

  localparam int NUM_BLOCKS = BIT_SIZE / REGISTER_SIZE;
  localparam int IDX_W      = $clog2(NUM_BLOCKS) + 1;
  localparam int TMO_W      = $clog2(TIMEOUT + 1);
  localparam int RTY_W      = $clog2(MAX_RETRIES + 2);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_WAIT,
    S_COLLECT,
    S_ABORT
  } state_t;

  state_t                     state;
  state_t                     state_next;
  logic [IDX_W-1:0]           idx_cnt;
  logic [TMO_W-1:0]           tmo_cnt;
  logic [RTY_W-1:0]           retry_cnt;
  logic                       accept;
  logic                       accept_last;
  logic [IDX_W-1:0]           accept_idx;
  logic [REGISTER_SIZE-1:0]   shaped;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    accept_idx  = idx_cnt;
    trigger_out = 1'b0;
    fail_out    = 1'b0;
    busy_out    = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (start_in) state_next = S_REQUEST;
      end
      S_REQUEST: begin
        trigger_out = 1'b1;
        state_next  = S_WAIT;
      end
      S_WAIT: begin
        // The first valid word of a burst is always index 0, whatever idx_cnt holds.
        accept_idx = '0;
        if (rand_valid_in) begin
          accept     = 1'b1;
          state_next = (accept_idx == LAST_IDX) ? S_IDLE : S_COLLECT;
        end else if (tmo_cnt == TMO_LAST) begin
          state_next = S_ABORT;
        end
      end
      S_COLLECT: begin
        if (rand_valid_in) begin
          accept     = 1'b1;
          state_next = (accept_idx == LAST_IDX) ? S_IDLE : S_COLLECT;
        end else begin
          state_next = S_ABORT;
        end
      end
      S_ABORT: begin
        if (retry_cnt >= RTY_MAX) begin
          fail_out   = 1'b1;
          state_next = S_IDLE;
        end else begin
          state_next = S_REQUEST;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    accept_last = accept && (accept_idx == LAST_IDX);
    shaped      = rand_in;
    // With a single block both forcings land on the same word.
    if (accept_idx == '0) shaped[0] = 1'b1;
    if (accept_idx == LAST_IDX) shaped[REGISTER_SIZE-1] = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      idx_cnt   <= '0;
      tmo_cnt   <= '0;
      retry_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_in) retry_cnt <= '0;
        end
        S_REQUEST: begin
          tmo_cnt <= '0;
          idx_cnt <= '0;
        end
        S_WAIT: begin
          if (!rand_valid_in) tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
        S_ABORT: begin
          retry_cnt <= retry_cnt + RTY_W'(1);
        end
        default: ;
      endcase
      if (accept) idx_cnt <= accept_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      word_out       <= '0;
      word_valid_out <= 1'b0;
      word_last_out  <= 1'b0;
      done_out       <= 1'b0;
    end else begin
      word_valid_out <= accept;
      word_last_out  <= accept_last;
      done_out       <= accept_last;
      if (accept) word_out <= shaped;
    end
  end

endmodule

// File: tb/tb_rand_candidate_shaper.sv
// tb/tb_rand_candidate_shaper.sv - randomized bench for rand_candidate_shaper against a burst-level reference model
module tb_rand_candidate_shaper;

  localparam int RS = 32;
  localparam int BS = 4096;
  localparam int NB = BS / RS;
  localparam int MR = 3;
  localparam int TO = 16;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          start_in;
  logic [RS-1:0] rand_in;
  logic          rand_valid_in;
  logic          trigger_out;
  logic [RS-1:0] word_out;
  logic          word_valid_out;
  logic          word_last_out;
  logic          done_out;
  logic          fail_out;
  logic          busy_out;

  rand_candidate_shaper #(
    .REGISTER_SIZE(RS),
    .BIT_SIZE(BS),
    .MAX_RETRIES(MR),
    .TIMEOUT(TO)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .start_in(start_in),
    .rand_in(rand_in),
    .rand_valid_in(rand_valid_in),
    .trigger_out(trigger_out),
    .word_out(word_out),
    .word_valid_out(word_valid_out),
    .word_last_out(word_last_out),
    .done_out(done_out),
    .fail_out(fail_out),
    .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  int trig_cnt = 0, done_cnt = 0, fail_cnt = 0, last_cnt = 0;
  int done_cyc = 0, last_cyc = 0;
  logic [RS-1:0] out_q[$];
  bit            last_q[$];
  logic [RS-1:0] burst[NB];

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (rst_in) begin
      if (trigger_out) trig_cnt <= trig_cnt + 1;
      if (fail_out) fail_cnt <= fail_cnt + 1;
      if (done_out) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (word_last_out) begin
        last_cnt <= last_cnt + 1;
        last_cyc <= cyc;
      end
      if (word_valid_out) begin
        out_q.push_back(word_out);
        last_q.push_back(word_last_out);
      end
    end
  end

  // Candidate rules: word 0 is made odd, the final word gets its top bit set.
  function automatic logic [RS-1:0] shaped(input logic [RS-1:0] w, input int idx);
    logic [RS-1:0] r;
    r = w;
    if (idx == 0) r = r | {{(RS-1){1'b0}}, 1'b1};
    if (idx == NB - 1) r = r | {1'b1, {(RS-1){1'b0}}};
    return r;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < NB; i++) burst[i] = $urandom();
  endtask

  task automatic do_start();
    @(posedge clk_in); #1;
    start_in  = 1'b1;
    start_cyc = cyc;
    @(posedge clk_in); #1;
    start_in  = 1'b0;
  endtask

  // Upstream generator: waits for trigger, idles `delay` cycles, then streams n words of burst[].
  task automatic respond(input int n, input int delay);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk_in);
      if (trigger_out) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL trigger_wait: trigger_out seen 0 times in 60 cycles, need 1");
      return;
    end
    repeat (delay) @(posedge clk_in);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in); #1;
      rand_valid_in = 1'b1;
      rand_in       = burst[i];
    end
    @(posedge clk_in); #1;
    rand_valid_in = 1'b0;
    rand_in       = $urandom();
  endtask

  task automatic test_reset();
    rst_in = 1'b0; start_in = 1'b0; rand_valid_in = 1'b0; rand_in = '0;
    repeat (3) @(negedge clk_in);
    n_vec++; if (trigger_out !== 1'b0) begin n_err++; $display("FAIL reset_trigger: got %b need 0", trigger_out); end
    n_vec++; if (word_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b need 0", word_valid_out); end
    n_vec++; if (word_last_out !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b need 0", word_last_out); end
    n_vec++; if (done_out !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b need 0", done_out); end
    n_vec++; if (fail_out !== 1'b0) begin n_err++; $display("FAIL reset_fail: got %b need 0", fail_out); end
    n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b need 0", busy_out); end
    n_vec++; if (word_out !== '0) begin n_err++; $display("FAIL reset_word: got %h need 0", word_out); end
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(negedge clk_in);
    n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL post_reset_busy: got %b need 0", busy_out); end
  endtask

  task automatic test_zero_burst();
    int b, t0, d0;
    for (int i = 0; i < NB; i++) burst[i] = '0;
    b = out_q.size(); t0 = trig_cnt; d0 = done_cnt;
    do_start();
    respond(NB, 0);
    repeat (3) @(negedge clk_in);
    n_vec++; if (out_q.size() - b != NB) begin n_err++; $display("FAIL zero_count: got %0d words need %0d", out_q.size() - b, NB); end
    if (out_q.size() - b == NB) begin
      n_vec++; if (out_q[b] !== 32'h0000_0001) begin n_err++; $display("FAIL zero_word0: got %h need 00000001", out_q[b]); end
      n_vec++; if (out_q[b+NB-1] !== 32'h8000_0000) begin n_err++; $display("FAIL zero_word_last: got %h need 80000000", out_q[b+NB-1]); end
      for (int i = 1; i < NB - 1; i++) begin
        n_vec++; if (out_q[b+i] !== 32'h0) begin n_err++; $display("FAIL zero_word[%0d]: got %h need 00000000", i, out_q[b+i]); end
      end
      for (int i = 0; i < NB; i++) begin
        n_vec++; if (last_q[b+i] !== (i == NB - 1)) begin n_err++; $display("FAIL zero_last_flag[%0d]: got %b need %b", i, last_q[b+i], (i == NB - 1)); end
      end
    end
    n_vec++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL zero_done: got %0d pulses need 1", done_cnt - d0); end
    n_vec++; if (trig_cnt - t0 != 1) begin n_err++; $display("FAIL zero_trig: got %0d pulses need 1", trig_cnt - t0); end
    // 131 cycles counting the start cycle itself: done is seen 130 cycles after it.
    n_vec++; if (done_cyc - start_cyc != 130) begin n_err++; $display("FAIL zero_latency: got %0d need 130", done_cyc - start_cyc); end
    n_vec++; if (last_cyc != done_cyc) begin n_err++; $display("FAIL zero_last_with_done: last at %0d done at %0d", last_cyc, done_cyc); end
    n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL zero_busy_after: got %b need 0", busy_out); end
  endtask

  task automatic test_random_bursts();
    int b, d0, dly;
    for (int k = 0; k < 3; k++) begin
      fill_random();
      dly = (k == 2) ? TO - 1 : int'($urandom_range(0, TO - 1));
      b = out_q.size(); d0 = done_cnt;
      do_start();
      respond(NB, dly);
      repeat (3) @(negedge clk_in);
      n_vec++; if (out_q.size() - b != NB) begin n_err++; $display("FAIL rand_count[%0d]: got %0d need %0d", k, out_q.size() - b, NB); end
      if (out_q.size() - b == NB) begin
        for (int i = 0; i < NB; i++) begin
          n_vec++; if (out_q[b+i] !== shaped(burst[i], i)) begin n_err++; $display("FAIL rand_word[%0d][%0d]: got %h need %h", k, i, out_q[b+i], shaped(burst[i], i)); end
        end
      end
      n_vec++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL rand_done[%0d] (delay %0d): got %0d need 1", k, dly, done_cnt - d0); end
    end
  endtask

  task automatic test_wait_boundary();
    int b, t0, d0;
    fill_random();
    b = out_q.size(); t0 = trig_cnt; d0 = done_cnt;
    do_start();
    respond(1, TO);
    fill_random();
    respond(NB, 0);
    repeat (3) @(negedge clk_in);
    n_vec++; if (trig_cnt - t0 != 2) begin n_err++; $display("FAIL late_trig: got %0d need 2", trig_cnt - t0); end
    n_vec++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL late_done: got %0d need 1", done_cnt - d0); end
    n_vec++; if (out_q.size() - b != NB) begin n_err++; $display("FAIL late_count: got %0d need %0d", out_q.size() - b, NB); end
    if (out_q.size() - b == NB) begin
      for (int i = 0; i < NB; i++) begin
        n_vec++; if (out_q[b+i] !== shaped(burst[i], i)) begin n_err++; $display("FAIL late_word[%0d]: got %h need %h", i, out_q[b+i], shaped(burst[i], i)); end
      end
    end
  endtask

  task automatic test_gap();
    int b, t0, d0, l0, f0;
    fill_random();
    b = out_q.size(); t0 = trig_cnt; d0 = done_cnt; l0 = last_cnt; f0 = fail_cnt;
    do_start();
    respond(50, 0);
    fill_random();
    respond(NB, 0);
    repeat (3) @(negedge clk_in);
    n_vec++; if (trig_cnt - t0 != 2) begin n_err++; $display("FAIL gap_trig: got %0d need 2", trig_cnt - t0); end
    n_vec++; if (last_cnt - l0 != 1) begin n_err++; $display("FAIL gap_last: got %0d need 1", last_cnt - l0); end
    n_vec++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL gap_done: got %0d need 1", done_cnt - d0); end
    n_vec++; if (fail_cnt - f0 != 0) begin n_err++; $display("FAIL gap_fail: got %0d need 0", fail_cnt - f0); end
    n_vec++; if (out_q.size() - b != 50 + NB) begin n_err++; $display("FAIL gap_count: got %0d need %0d", out_q.size() - b, 50 + NB); end
    if (out_q.size() - b == 50 + NB) begin
      for (int i = 0; i < NB; i++) begin
        n_vec++; if (out_q[b+50+i] !== shaped(burst[i], i)) begin n_err++; $display("FAIL gap_word[%0d]: got %h need %h", i, out_q[b+50+i], shaped(burst[i], i)); end
      end
    end
  endtask

  task automatic test_timeout_fail();
    int t0, f0, d0, l0;
    t0 = trig_cnt; f0 = fail_cnt; d0 = done_cnt; l0 = last_cnt;
    do_start();
    for (int i = 0; i < 200 && fail_cnt == f0; i++) @(negedge clk_in);
    @(negedge clk_in);
    n_vec++; if (fail_cnt - f0 != 1) begin n_err++; $display("FAIL tmo_fail: got %0d pulses need 1", fail_cnt - f0); end
    n_vec++; if (trig_cnt - t0 != MR + 1) begin n_err++; $display("FAIL tmo_trig: got %0d need %0d", trig_cnt - t0, MR + 1); end
    n_vec++; if (done_cnt - d0 != 0) begin n_err++; $display("FAIL tmo_done: got %0d need 0", done_cnt - d0); end
    n_vec++; if (last_cnt - l0 != 0) begin n_err++; $display("FAIL tmo_last: got %0d need 0", last_cnt - l0); end
    n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL tmo_busy: got %b need 0", busy_out); end
  endtask

  task automatic test_start_ignored();
    int b, t0, d0;
    fill_random();
    b = out_q.size(); t0 = trig_cnt; d0 = done_cnt;
    do_start();
    fork
      respond(NB, 0);
      begin
        repeat (40) @(posedge clk_in);
        #1 start_in = 1'b1;
        @(posedge clk_in);
        #1 start_in = 1'b0;
      end
    join
    repeat (8) @(negedge clk_in);
    n_vec++; if (out_q.size() - b != NB) begin n_err++; $display("FAIL restart_count: got %0d need %0d", out_q.size() - b, NB); end
    n_vec++; if (trig_cnt - t0 != 1) begin n_err++; $display("FAIL restart_trig: got %0d need 1", trig_cnt - t0); end
    n_vec++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL restart_done: got %0d need 1", done_cnt - d0); end
    n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL restart_busy: got %b need 0", busy_out); end
    if (out_q.size() - b == NB) begin
      for (int i = 0; i < NB; i++) begin
        n_vec++; if (out_q[b+i] !== shaped(burst[i], i)) begin n_err++; $display("FAIL restart_word[%0d]: got %h need %h", i, out_q[b+i], shaped(burst[i], i)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int b, d0, f0, l0;
    logic [RS+5:0] outs;
    fill_random();
    b = out_q.size(); d0 = done_cnt; f0 = fail_cnt; l0 = last_cnt;
    do_start();
    fork
      respond(NB, 0);
      begin
        for (int i = 0; i < 300 && out_q.size() < b + 70; i++) @(negedge clk_in);
        n_vec++; if (out_q.size() < b + 70) begin n_err++; $display("FAIL rstmid_reach70: got %0d words need 70", out_q.size() - b); end
        #2 rst_in = 1'b0;
        #1 outs = {trigger_out, word_valid_out, word_last_out, done_out, fail_out, busy_out, word_out};
        n_vec++; if (outs !== '0) begin n_err++; $display("FAIL rstmid_outputs: got %h need 0", outs); end
      end
    join
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    n_vec++; if (done_cnt - d0 != 0) begin n_err++; $display("FAIL rstmid_done: got %0d need 0", done_cnt - d0); end
    n_vec++; if (fail_cnt - f0 != 0) begin n_err++; $display("FAIL rstmid_fail: got %0d need 0", fail_cnt - f0); end
    n_vec++; if (last_cnt - l0 != 0) begin n_err++; $display("FAIL rstmid_last: got %0d need 0", last_cnt - l0); end
    n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b need 0", busy_out); end
    fill_random();
    b = out_q.size(); d0 = done_cnt;
    do_start();
    respond(NB, 0);
    repeat (3) @(negedge clk_in);
    n_vec++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL rstmid_rerun_done: got %0d need 1", done_cnt - d0); end
    n_vec++; if (out_q.size() - b != NB) begin n_err++; $display("FAIL rstmid_rerun_count: got %0d need %0d", out_q.size() - b, NB); end
    if (out_q.size() - b == NB) begin
      for (int i = 0; i < NB; i++) begin
        n_vec++; if (out_q[b+i] !== shaped(burst[i], i)) begin n_err++; $display("FAIL rstmid_word[%0d]: got %h need %h", i, out_q[b+i], shaped(burst[i], i)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_burst();
    test_random_bursts();
    test_wait_boundary();
    test_gap();
    test_timeout_fail();
    test_start_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
